// File: rtl/ro_puf_pkg.sv
// Shared types and defaults for the ring-oscillator PUF sequencer.
// Holds the FSM state encoding, select/challenge widths and parameter defaults.
package ro_puf_pkg;

  localparam int RO_SEL_W = 3;
  localparam int CHAL_W   = 6;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_WINDOW = 1024;
  localparam int DEF_SETTLE = 8;
  localparam int DEF_MARGIN = 4;

  // ST_ prefix keeps the literals clear of the SETTLE parameter name
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_COMPARE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ro_edge_counter.sv
// Counts synchronized rising edges of one asynchronous RO mux output.
// Two-flop synchronizer, rising-edge detector and a saturating counter with clear/enable.
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sync1_reg;
  logic             sync2_reg;
  logic             prev_reg;
  logic             rise;
  logic [CNT_W-1:0] count_reg;

  assign rise  = sync2_reg & ~prev_reg;
  assign count = count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      sync1_reg <= ro;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      // clear wins over counting; saturate instead of wrapping
      if (clr)
        count_reg <= '0;
      else if (en && rise && (count_reg != CNT_MAX))
        count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ro_pair_sequencer.sv
// Sequences one RO-PUF evaluation: select pair, settle, count both ROs, compare.
// Optional margin flag built only when RO_MARGIN_FLAG_EN is defined.
module ro_pair_sequencer
  import ro_puf_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WINDOW = DEF_WINDOW,
  parameter int SETTLE = DEF_SETTLE,
  parameter int MARGIN = DEF_MARGIN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CHAL_W-1:0]   challenge,
  input  logic                ro_a,
  input  logic                ro_b,
  output logic [RO_SEL_W-1:0] sel_a,
  output logic [RO_SEL_W-1:0] sel_b,
  output logic                ro_en,
  output logic                busy,
  output logic                done,
  output logic                resp,
  output logic [CNT_W-1:0]    count_a,
  output logic [CNT_W-1:0]    count_b,
  output logic                unreliable
);

  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX);

  state_t              state_reg;
  logic [TMR_W-1:0]    timer_reg;
  logic [RO_SEL_W-1:0] sel_a_reg;
  logic [RO_SEL_W-1:0] sel_b_reg;
  logic                ro_en_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                resp_reg;
  logic [CNT_W-1:0]    count_a_reg;
  logic [CNT_W-1:0]    count_b_reg;

  logic [1:0]          ro_vec;
  logic [CNT_W-1:0]    cnt [2];
  logic                cnt_clr;
  logic                cnt_en;

  assign ro_vec  = {ro_b, ro_a};
  assign cnt_clr = (state_reg == ST_SETTLE) && (timer_reg == '0);
  assign cnt_en  = (state_reg == ST_COUNT);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      ro_edge_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .ro   (ro_vec[gi]),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .count(cnt[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      timer_reg   <= '0;
      sel_a_reg   <= '0;
      sel_b_reg   <= '0;
      ro_en_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      resp_reg    <= 1'b0;
      count_a_reg <= '0;
      count_b_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            sel_a_reg <= challenge[CHAL_W-1:RO_SEL_W];
            sel_b_reg <= challenge[RO_SEL_W-1:0];
            busy_reg  <= 1'b1;
            ro_en_reg <= 1'b1;
            timer_reg <= TMR_W'(SETTLE - 1);
            state_reg <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (timer_reg == '0) begin
            timer_reg <= TMR_W'(WINDOW - 1);
            state_reg <= ST_COUNT;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        ST_COUNT: begin
          if (timer_reg == '0) begin
            ro_en_reg <= 1'b0;
            state_reg <= ST_COMPARE;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        ST_COMPARE: begin
          resp_reg    <= (cnt[0] > cnt[1]);
          count_a_reg <= cnt[0];
          count_b_reg <= cnt[1];
          done_reg    <= 1'b1;
          state_reg   <= ST_DONE;
        end
        ST_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef RO_MARGIN_FLAG_EN
  localparam logic [CNT_W:0] MARGIN_V = (CNT_W + 1)'(MARGIN);

  logic [CNT_W-1:0] diff;
  logic             unrel_reg;

  assign diff = (cnt[0] > cnt[1]) ? (cnt[0] - cnt[1]) : (cnt[1] - cnt[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      unrel_reg <= 1'b0;
    else if (state_reg == ST_COMPARE)
      unrel_reg <= ({1'b0, diff} < MARGIN_V);
  end

  assign unreliable = unrel_reg;
`else
  assign unreliable = 1'b0;
`endif

  assign sel_a   = sel_a_reg;
  assign sel_b   = sel_b_reg;
  assign ro_en   = ro_en_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign resp    = resp_reg;
  assign count_a = count_a_reg;
  assign count_b = count_b_reg;

endmodule
